// File: rtl/bus_line_arbiter.sv
// Two-master cache-line bus arbiter: I-side (F) and D-side (M) compete for
// burst ownership of a single bus, with D-side priority bounded by a starvation counter.
module bus_line_arbiter #(
    parameter int unsigned BLOCKSIZE    = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         HRequestF,
    input  logic [31:0]                  HAddrF,
    input  logic                         HRequestM,
    input  logic                         HWriteM,
    input  logic [31:0]                  HAddrM,
    input  logic                         HReady,
    output logic [31:0]                  HAddr,
    output logic                         HWrite,
    output logic                         HRequest,
    output logic                         HReadyF,
    output logic                         HReadyM,
    output logic                         GrantF,
    output logic                         GrantM,
    output logic [$clog2(BLOCKSIZE)-1:0] Beat
);

    localparam int unsigned BW = $clog2(BLOCKSIZE);
    localparam int unsigned SW = $clog2(STARVE_LIMIT) + 1;

    localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BLOCKSIZE - 1);
    localparam logic [SW-1:0] STV_ONE   = SW'(1);
    localparam logic [SW-1:0] STV_LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST_F = 2'd1,
        BURST_M = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            grant_f_q, grant_m_q;

    logic            owner_req;
    logic            handshake;
    logic            m_wins;
    logic [31:0]     sel_addr;
    logic            unused_addr_bits;

    // Low address bits are replaced by the beat index and the word offset.
    assign unused_addr_bits = ^{HAddrF[BW+1:0], HAddrM[BW+1:0]};

    assign m_wins = HRequestM && (!HRequestF || (starve_q < STV_LIMIT));

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                beat_d = '0;
                if (m_wins) begin
                    state_d = BURST_M;
                    if (HRequestF && (starve_q < STV_LIMIT)) begin
                        starve_d = starve_q + STV_ONE;
                    end
                end else if (HRequestF) begin
                    state_d  = BURST_F;
                    starve_d = '0;
                end
            end
            BURST_F, BURST_M: begin
                if (!owner_req) begin
                    // Owner withdrew mid-burst: abandon the line without counting a beat.
                    state_d = IDLE;
                    beat_d  = '0;
                end else if (HReady) begin
                    if (beat_q == BEAT_LAST) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BEAT_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            starve_q  <= '0;
            grant_f_q <= 1'b0;
            grant_m_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            starve_q  <= starve_d;
            grant_f_q <= (state_d == BURST_F);
            grant_m_q <= (state_d == BURST_M);
        end
    end

    always_comb begin
        owner_req = 1'b0;
        sel_addr  = '0;
        if (grant_f_q) begin
            owner_req = HRequestF;
            sel_addr  = HAddrF;
        end else if (grant_m_q) begin
            owner_req = HRequestM;
            sel_addr  = HAddrM;
        end
    end

    assign handshake = owner_req & HReady;

    assign HRequest = owner_req;
    assign HWrite   = grant_m_q & HWriteM;
    assign HReadyF  = grant_f_q & handshake;
    assign HReadyM  = grant_m_q & handshake;
    assign GrantF   = grant_f_q;
    assign GrantM   = grant_m_q;
    assign Beat     = beat_q;
    assign HAddr    = (grant_f_q || grant_m_q) ? {sel_addr[31:BW+2], beat_q, 2'b00} : '0;

endmodule

// File: doc/bus_line_arbiter.md
BUS_LINE_ARBITER -- requirements
Module: bus_line_arbiter

Interface
REQ-001 SHALL have parameter BLOCKSIZE, default 4, meaning words per cache-line burst (power of 2, >=2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, meaning consecutive M-bursts granted while F waits before F is forced.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 HRequestF  input  1  instruction-cache fill request.
REQ-006 HAddrF  input  32  instruction-cache line address.
REQ-007 HRequestM  input  1  data-cache fill/writeback request.
REQ-008 HWriteM  input  1  data-cache request is a write.
REQ-009 HAddrM  input  32  data-cache line address.
REQ-010 HReady  input  1  bus beat completes this cycle.
REQ-011 HAddr  output  32  bus address.
REQ-012 HWrite  output  1  bus write strobe.
REQ-013 HRequest  output  1  bus transfer valid.
REQ-014 HReadyF  output  1  beat done for I-side.
REQ-015 HReadyM  output  1  beat done for D-side.
REQ-016 GrantF  output  1  I-side owns bus.
REQ-017 GrantM  output  1  D-side owns bus.
REQ-018 Beat  output  log2(BLOCKSIZE)  current beat index within burst.

Function
REQ-019 SHALL implement FSM states IDLE, BURST_F, BURST_M, all registered; GrantF=1 only in BURST_F, GrantM=1 only in BURST_M.
REQ-020 In IDLE, HRequest=0, HWrite=0, HAddr=0, Beat=0, HReadyF=HReadyM=0.
REQ-021 IDLE->BURST_M when HRequestM=1 and (HRequestF=0 or StarveCnt<STARVE_LIMIT).
REQ-022 IDLE->BURST_F when HRequestF=1 and (HRequestM=0 or StarveCnt>=STARVE_LIMIT).
REQ-023 A grant decided in IDLE SHALL drive the bus starting the next cycle (1-cycle arbitration latency).
REQ-024 In BURST_x: HRequest=HRequestx; HWrite=HWriteM in BURST_M, 0 in BURST_F.
REQ-025 HAddr in BURST_x SHALL be {HAddrx[31:log2(BLOCKSIZE)+2], Beat, 2'b00}.
REQ-026 Beat handshake = HRequest & HReady; HReadyx=HReady & HRequest in BURST_x, 0 for the non-owner.
REQ-027 On each handshake, Beat increments by 1; on handshake with Beat=BLOCKSIZE-1, Beat wraps to 0 and FSM returns to IDLE.
REQ-028 HReady=0 SHALL hold Beat, HAddr, HWrite unchanged (wait states).
REQ-029 If owner drops its request mid-burst (HRequestx=0), FSM SHALL return to IDLE next cycle with Beat=0 (abort); no beat is counted.
REQ-030 StarveCnt (width log2(STARVE_LIMIT)+1) SHALL increment, saturating at STARVE_LIMIT, on each IDLE->BURST_M taken while HRequestF=1.
REQ-031 StarveCnt SHALL clear to 0 on every IDLE->BURST_F.
REQ-032 Ownership SHALL never change mid-burst, regardless of other requester.
REQ-033 At least one IDLE cycle SHALL separate consecutive bursts.

Reset
REQ-034 reset=1 SHALL asynchronously force state IDLE, Beat=0, StarveCnt=0, all outputs 0, including during an active burst; pending requests re-arbitrate after reset deasserts.

Verification
REQ-035 Single F request, HAddrF=0x0000_1238, HReady=1 -> GrantF next cycle, HAddr 0x1230,0x1234,0x1238,0x123C on 4 successive cycles, HReadyF=1 each, IDLE after.
REQ-036 Both request simultaneously, StarveCnt=0 -> BURST_M first (HWrite follows HWriteM), BURST_F after one IDLE cycle; StarveCnt ends 0.
REQ-037 HRequestM held high with HRequestF high for 8 consecutive M bursts -> 9th grant goes to F, StarveCnt cleared.
REQ-038 HReady low for 3 cycles at Beat=2 -> HAddr/Beat held 3 cycles, no HReadyM, burst completes on 4th beat afterward.
REQ-039 HRequestM dropped at Beat=1 -> IDLE next cycle, Beat=0; pending F granted following cycle.
REQ-040 reset asserted at Beat=2 in BURST_F -> outputs 0 immediately without clock edge; after release with HRequestF=1, burst restarts at Beat=0.
